mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: grants the shared bus, runs one read/write/
// increment per start pulse against an internal array, pulses rdy on completion.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int GNT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] wdata,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              err,
  output logic [15:0]       txn_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] M_RD  = 2'b00;
  localparam logic [1:0] M_WR  = 2'b01;
  localparam logic [1:0] M_INC = 2'b10;
  localparam logic [1:0] M_BAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_DONE,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_wait;
  logic [7:0]        r_idle;

  logic              r_gnt;
  logic              r_rdy;
  logic              r_err;
  logic              r_oe;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_txn;

  logic              w_start_cmd;
  logic              w_timeout;
  logic              w_fin;
  logic              w_oob;
  logic              w_bad;
  logic              w_we;
  logic              w_rd_like;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_wval;

  // Out-of-range check only exists when the address space exceeds the array.
  generate
    if (DEPTH < (2 ** ADDR_W)) begin : g_oob
      assign w_oob = (32'(r_addr) >= 32'(DEPTH));
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  assign w_idx       = r_addr[IDX_W-1:0];
  assign w_old       = r_mem[w_idx];
  assign w_start_cmd = (r_state == S_GRANT) && start;
  assign w_timeout   = (r_idle == 8'(GNT_TIMEOUT - 1));
  assign w_fin       = (r_state == S_BUSY) && (r_wait == 3'd0);
  assign w_bad       = (r_mode == M_BAD) || w_oob;
  assign w_rd_like   = (r_mode == M_RD) || (r_mode == M_INC);
  assign w_wval      = (r_mode == M_INC) ? w_old + DATA_W'(1)
                                         : r_wdata;

  // A reset on the completing edge must suppress the array update.
  assign w_we = w_fin && !rst && !w_bad &&
                ((r_mode == M_WR) || (r_mode == M_INC));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req) w_next = S_GRANT;
      end
      S_GRANT: begin
        if (start)          w_next = S_BUSY;
        else if (!req)      w_next = S_IDLE;
        else if (w_timeout) w_next = S_HOLD;
      end
      S_BUSY: begin
        if (r_wait == 3'd0) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = req ? S_GRANT : S_IDLE;
      end
      S_HOLD: begin
        if (!req) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= w_wval;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_mode  <= '0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_idle  <= '0;
      r_gnt   <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_oe    <= 1'b0;
      r_rdata <= '0;
      r_txn   <= '0;
    end else begin
      r_gnt <= (w_next == S_GRANT) ||
               (w_next == S_BUSY)  ||
               (w_next == S_DONE);
      r_rdy <= w_fin;
      r_err <= w_fin && w_bad;
      r_oe  <= w_fin && !w_bad && w_rd_like;

      if (w_fin) begin
        r_txn <= r_txn + 16'd1;
        if (!w_bad && w_rd_like) r_rdata <= w_old;
      end

      if (w_start_cmd) begin
        r_addr  <= addr;
        r_mode  <= mode;
        r_wdata <= wdata;
        r_wait  <= 3'(WAIT_CYCLES);
      end else if ((r_state == S_BUSY) && (r_wait != 3'd0)) begin
        r_wait <= r_wait - 3'd1;
      end

      if ((r_state == S_GRANT) && !start && req)
        r_idle <= r_idle + 8'd1;
      else
        r_idle <= '0;
    end
  end

  assign gnt      = r_gnt;
  assign rdy      = r_rdy;
  assign err      = r_err;
  assign rdata_oe = r_oe;
  assign rdata    = r_rdata;
  assign txn_cnt  = r_txn;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl against a transaction-level model.
module tb_mem_bus_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int WAITC = 1;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          start;
  logic [AW-1:0] addr;
  logic [1:0]    mode;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rdy;
  logic [DW-1:0] rdata;
  logic          rdata_oe;
  logic          err;
  logic [15:0]   txn_cnt;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WAITC),
    .GNT_TIMEOUT(TMO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .start(start),
    .addr(addr),
    .mode(mode),
    .wdata(wdata),
    .gnt(gnt),
    .rdy(rdy),
    .rdata(rdata),
    .rdata_oe(rdata_oe),
    .err(err),
    .txn_cnt(txn_cnt)
  );

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rdata;
  logic [15:0]   m_txn;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic model_cmd(input  logic [1:0]    md,
                           input  logic [AW-1:0] a,
                           input  logic [DW-1:0] wd,
                           output logic          e_err,
                           output logic          e_oe);
    int v;
    m_txn = m_txn + 16'd1;
    e_err = 1'b0;
    e_oe  = 1'b0;
    if (md == 2'd3 || int'(a) >= DEPTH) begin
      e_err = 1'b1;
    end else if (md == 2'd0) begin
      m_rdata = m_mem[a];
      e_oe    = 1'b1;
    end else if (md == 2'd1) begin
      m_mem[a] = wd;
    end else begin
      m_rdata  = m_mem[a];
      v        = (int'(m_mem[a]) + 1) % 256;
      m_mem[a] = 8'(v);
      e_oe     = 1'b1;
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (gnt) begin
        ok = 1'b1;
        return;
      end
      tick;
    end
    chk("gnt_wait", 32'd0, 32'd1);
  endtask

  task automatic do_cmd(input logic [1:0]    md,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd,
                        input bit            keep_req,
                        input bit            drop_req);
    bit   ok;
    logic e_err;
    logic e_oe;
    int   c;
    req = 1'b1;
    wait_gnt(ok);
    if (!ok) return;
    start = 1'b1;
    mode  = md;
    addr  = a;
    wdata = wd;
    if (drop_req) req = 1'b0;
    model_cmd(md, a, wd, e_err, e_oe);
    for (c = 1; c <= WAITC + 4; c++) begin
      tick;
      start = 1'($urandom_range(0, 1));
      req   = 1'($urandom_range(0, 1));
      addr  = 8'($urandom);
      mode  = 2'($urandom);
      wdata = 8'($urandom);
      if (rdy) break;
      chk("busy_gnt", gnt, 1);
    end
    start = 1'b0;
    req   = keep_req;
    chk("latency", c, WAITC + 2);
    chk("rdy", rdy, 1);
    chk("done_gnt", gnt, 1);
    chk("err", err, e_err);
    chk("rdata_oe", rdata_oe, e_oe);
    chk("rdata", rdata, m_rdata);
    chk("txn_cnt", txn_cnt, m_txn);
    tick;
    chk("rdy_pulse", rdy, 0);
    chk("exit_gnt", gnt, keep_req);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] prior;
    int cnt;
    rst   = 1'b1;
    req   = 1'b0;
    start = 1'b0;
    addr  = '0;
    mode  = '0;
    wdata = '0;
    m_rdata = '0;
    m_txn   = '0;
    repeat (3) tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_oe", rdata_oe, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_txn", txn_cnt, 0);
    rst = 1'b0;
    tick;
    chk("idle_gnt", gnt, 0);
    req = 1'b1;
    tick;
    chk("gnt_rise", gnt, 1);
    chk("gnt_rise_rdy", rdy, 0);
    chk("gnt_rise_txn", txn_cnt, 0);

    for (int i = 0; i < DEPTH; i++)
      do_cmd(2'd1, 8'(i), 8'($urandom), 1'b1, 1'b0);

    do_cmd(2'd1, 8'h10, 8'hA5, 1'b1, 1'b0);
    do_cmd(2'd0, 8'h10, 8'h00, 1'b1, 1'b0);
    chk("rd_a5", rdata, 8'hA5);
    do_cmd(2'd1, 8'h20, 8'hFF, 1'b1, 1'b0);
    do_cmd(2'd2, 8'h20, 8'h00, 1'b1, 1'b0);
    chk("inc_old", rdata, 8'hFF);
    do_cmd(2'd0, 8'h20, 8'h00, 1'b0, 1'b0);
    chk("inc_wrap", rdata, 8'h00);
    do_cmd(2'd3, 8'h05, 8'h3C, 1'b1, 1'b0);
    do_cmd(2'd0, 8'h05, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 200; i++)
      do_cmd(2'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));

    req = 1'b0;
    repeat (2) tick;
    req = 1'b1;
    cnt = 0;
    tick;
    while (gnt && cnt < 40) begin
      cnt++;
      tick;
    end
    chk("tmo_len", cnt, TMO);
    repeat (5) tick;
    chk("hold_gnt", gnt, 0);
    req = 1'b0;
    tick;
    chk("hold_rel", gnt, 0);
    req = 1'b1;
    tick;
    chk("regrant", gnt, 1);

    prior = m_mem[8'h30];
    start = 1'b1;
    mode  = 2'd1;
    addr  = 8'h30;
    wdata = 8'h77;
    for (int i = 1; i <= WAITC + 1; i++) begin
      tick;
      start = 1'b0;
    end
    rst = 1'b1;
    req = 1'b0;
    tick;
    m_txn   = '0;
    m_rdata = '0;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_rdy", rdy, 0);
    chk("mid_rst_oe", rdata_oe, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_txn", txn_cnt, 0);
    rst = 1'b0;
    tick;
    do_cmd(2'd0, 8'h30, 8'h00, 1'b0, 1'b0);
    chk("no_abort_wr", rdata, prior);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
